// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM access controller: FSM and bus-mode
// encodings, idle pin levels, address field layout and phase-parameter limits.
package vram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    typedef enum logic {
        BUS_IN  = 1'b0,
        BUS_OUT = 1'b1
    } bus_mode_t;

    localparam logic STROBE_IDLE   = 1'b1;
    localparam logic TRISTATE_IDLE = 1'b1;
    localparam logic DIR_IDLE      = 1'b0;

    localparam int ADDR_W   = 15;
    localparam int VA14_BIT = 14;
    localparam int CHIP_AW  = 14;
    localparam int PHASE_W  = 4;

    function automatic bit phase_ok(input int n);
        return (n >= 1) && (n <= 15);
    endfunction

endpackage

// File: rtl/vram_phase_timer.sv
// Loadable 4-bit down-counter shared by every access phase; done while zero.
// Latency: load value N-1 gives a phase exactly N cycles long. No backpressure.
module vram_phase_timer
    import vram_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               done
);

    logic [PHASE_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vram_access_ctrl.sv
// Single-word VRAM read/write sequencer: TURN -> SETUP -> STROBE -> HOLD per request.
// Latency: accept to rsp_valid = [TURN] + SETUP + STROBE + 1; ready again after HOLD.
// Backpressure: req_ready only in IDLE; one request in flight, responses never stall.
module vram_access_ctrl
    import vram_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int TURN_CYCLES   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [15:0]         req_wdata,
    input  logic [1:0]          req_be,
    output logic                rsp_valid,
    output logic [15:0]         rsp_rdata,
    output logic                busy,
    output logic                vrd_n,
    output logic                vawr_n,
    output logic                vbwr_n,
    output logic                va14,
    output logic [CHIP_AW-1:0]  vaa,
    output logic [CHIP_AW-1:0]  vab,
    output logic [7:0]          vda_o,
    output logic [7:0]          vdb_o,
    input  logic [7:0]          vda_i,
    input  logic [7:0]          vdb_i,
    output logic                vd_tristate,
    output logic                lvl_vd_dir
);

    if (!phase_ok(SETUP_CYCLES) || !phase_ok(STROBE_CYCLES) ||
        !phase_ok(HOLD_CYCLES)  || !phase_ok(TURN_CYCLES)) begin : g_bad_phase
        $error("vram_access_ctrl: phase cycle parameters must lie in 1..15");
    end

    localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYCLES - 1);
    localparam logic [PHASE_W-1:0] STROBE_LD = PHASE_W'(STROBE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLD_LD   = PHASE_W'(HOLD_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TURN_LD   = PHASE_W'(TURN_CYCLES - 1);

    state_t             state, state_d;
    bus_mode_t          mode, mode_d;
    logic               ready_q;
    logic               accept;
    logic               leave_strobe;
    logic               tmr_load;
    logic [PHASE_W-1:0] tmr_val;
    logic               tmr_done;
    logic               strobe_d;

    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        wdata_q;
    logic [1:0]         be_q;
    logic               write_q;

    vram_phase_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state;
        mode_d       = mode;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        accept       = 1'b0;
        leave_strobe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    // Writes want the bus driven, reads want it released.
                    if (req_write != (mode == BUS_OUT)) begin
                        state_d = ST_TURN;
                        tmr_val = TURN_LD;
                        if (!req_write) begin
                            mode_d = BUS_IN;
                        end
                    end else begin
                        state_d = ST_SETUP;
                        tmr_val = SETUP_LD;
                    end
                end
            end
            ST_TURN: begin
                if (tmr_done) begin
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                    if (write_q) begin
                        mode_d = BUS_OUT;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    state_d      = ST_HOLD;
                    tmr_load     = 1'b1;
                    tmr_val      = HOLD_LD;
                    leave_strobe = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so the pins never glitch.
    assign strobe_d = (state_d == ST_STROBE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mode      <= BUS_IN;
            ready_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            write_q   <= 1'b0;
            vrd_n     <= STROBE_IDLE;
            vawr_n    <= STROBE_IDLE;
            vbwr_n    <= STROBE_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_d;
            mode      <= mode_d;
            ready_q   <= (state_d == ST_IDLE);
            vrd_n     <= ~(strobe_d & ~write_q);
            vawr_n    <= ~(strobe_d & write_q & be_q[0]);
            vbwr_n    <= ~(strobe_d & write_q & be_q[1]);
            rsp_valid <= leave_strobe;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                write_q <= req_write;
            end
            if (leave_strobe && !write_q) begin
                rsp_rdata <= {vdb_i, vda_i};
            end
        end
    end

    assign req_ready   = ready_q;
    assign busy        = (state != ST_IDLE);
    assign va14        = addr_q[VA14_BIT];
    assign vaa         = addr_q[CHIP_AW-1:0];
    assign vab         = addr_q[CHIP_AW-1:0];
    assign vda_o       = wdata_q[7:0];
    assign vdb_o       = wdata_q[15:8];
    assign vd_tristate = (mode == BUS_IN) ? TRISTATE_IDLE : ~TRISTATE_IDLE;
    assign lvl_vd_dir  = (mode == BUS_IN) ? DIR_IDLE : ~DIR_IDLE;

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Bench for vram_access_ctrl: timeline-based reference model with per-cycle compare,
// VRAM chip model, directed scenarios and a randomized request mix.
module tb_vram_access_ctrl;

    localparam int S   = 1;
    localparam int P   = 2;
    localparam int H   = 1;
    localparam int T   = 2;
    localparam int FAR = 1 << 30;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [14:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        vrd_n, vawr_n, vbwr_n, va14;
    logic [13:0] vaa, vab;
    logic [7:0]  vda_o, vdb_o, vda_i, vdb_i;
    logic        vd_tristate, lvl_vd_dir;

    vram_access_ctrl #(
        .SETUP_CYCLES(S), .STROBE_CYCLES(P), .HOLD_CYCLES(H), .TURN_CYCLES(T)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .vrd_n(vrd_n), .vawr_n(vawr_n), .vbwr_n(vbwr_n),
        .va14(va14), .vaa(vaa), .vab(vab),
        .vda_o(vda_o), .vdb_o(vdb_o), .vda_i(vda_i), .vdb_i(vdb_i),
        .vd_tristate(vd_tristate), .lvl_vd_dir(lvl_vd_dir)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // VRAM chips: level-sensitive writes, data driven only while vrd_n is low.
    logic [7:0] chip_a [32768];
    logic [7:0] chip_b [32768];
    logic [7:0] ref_a  [32768];
    logic [7:0] ref_b  [32768];

    always @(posedge clock) begin
        if (vawr_n === 1'b0) chip_a[{va14, vaa}] <= vda_o;
        if (vbwr_n === 1'b0) chip_b[{va14, vab}] <= vdb_o;
    end
    assign vda_i = (vrd_n === 1'b0) ? chip_a[{va14, vaa}] : 8'h00;
    assign vdb_i = (vrd_n === 1'b0) ? chip_b[{va14, vab}] : 8'h00;

    // Reference model: each accepted request becomes a timeline of cycle numbers.
    bit          m_in_rst = 1'b1;
    bit          m_mode = 1'b0;
    bit          m_mode_new = 1'b0;
    bit          m_write = 1'b0;
    int          m_ready = FAR, m_end = -1, m_acc = -100;
    int          m_sb_lo = -10, m_sb_hi = -10, m_rsp = -10, m_chg = FAR;
    logic [14:0] m_addr = '0;
    logic [15:0] m_wdata = '0, m_rdata = '0, m_rd_val = '0;
    logic [1:0]  m_be = '0;

    int cnt_awr = 0, cnt_bwr = 0, cnt_rd = 0, cnt_rsp = 0;
    int last_rsp = -1, prev_rsp = -1, vrd_fall = -1, tri_rise = -1;
    logic prev_vrd = 1'b1, prev_tri = 1'b1;

    always @(negedge clock) begin
        int  n, t;
        bit  sb, mis;
        n = cyc;
        if (!reset) begin
            m_in_rst = 1'b1;  m_mode = 1'b0;  m_write = 1'b0;  m_chg = FAR;
            m_ready = FAR;    m_end = -1;     m_acc = -100;
            m_sb_lo = -10;    m_sb_hi = -10;  m_rsp = -10;
            m_addr = '0;      m_wdata = '0;   m_rdata = '0;    m_be = '0;
        end else if (m_in_rst) begin
            m_in_rst = 1'b0;
            m_ready  = n + 1;
        end
        if (n >= m_chg) begin
            m_mode = m_mode_new;
            m_chg  = FAR;
        end
        if (n == m_rsp && !m_write) m_rdata = m_rd_val;
        sb = (n >= m_sb_lo) && (n <= m_sb_hi);

        chk("req_ready",   req_ready, !m_in_rst && n >= m_ready);
        chk("busy",        busy, n > m_acc && n < m_end);
        chk("vrd_n",       vrd_n, !(sb && !m_write));
        chk("vawr_n",      vawr_n, !(sb && m_write && m_be[0]));
        chk("vbwr_n",      vbwr_n, !(sb && m_write && m_be[1]));
        chk("rsp_valid",   rsp_valid, n == m_rsp);
        chk("rsp_rdata",   rsp_rdata, m_rdata);
        chk("va14_vaa",    {va14, vaa}, m_addr);
        chk("vab",         vab, m_addr[13:0]);
        chk("wdata_pins",  {vdb_o, vda_o}, m_wdata);
        chk("vd_tristate", vd_tristate, !m_mode);
        chk("lvl_vd_dir",  lvl_vd_dir, m_mode);
        chk("read_with_bus_driven", !vrd_n && (!vd_tristate || lvl_vd_dir), 1'b0);
        chk("strobes_exclusive",    !vrd_n && (!vawr_n || !vbwr_n), 1'b0);

        if (!vawr_n) cnt_awr++;
        if (!vbwr_n) cnt_bwr++;
        if (!vrd_n)  cnt_rd++;
        if (rsp_valid) begin
            cnt_rsp++;
            prev_rsp = last_rsp;
            last_rsp = n;
        end
        if (!vrd_n && prev_vrd) vrd_fall = n;
        if (vd_tristate && !prev_tri) tri_rise = n;
        prev_vrd = vrd_n;
        prev_tri = vd_tristate;

        if (reset && req_valid && !m_in_rst && n >= m_ready) begin
            mis     = req_write ? (m_mode == 1'b0) : (m_mode == 1'b1);
            t       = mis ? T : 0;
            m_acc   = n;
            m_write = req_write;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_be    = req_be;
            m_sb_lo = n + t + S + 1;
            m_sb_hi = n + t + S + P;
            m_rsp   = m_sb_hi + 1;
            m_ready = m_rsp + H;
            m_end   = m_ready;
            if (mis) begin
                m_mode_new = req_write;
                m_chg      = req_write ? n + t + 1 : n + 1;
            end
            if (req_write) begin
                if (req_be[0]) ref_a[req_addr] = req_wdata[7:0];
                if (req_be[1]) ref_b[req_addr] = req_wdata[15:8];
            end else begin
                m_rd_val = {ref_b[req_addr], ref_a[req_addr]};
            end
        end
    end

    task automatic clear_counts();
        cnt_awr = 0; cnt_bwr = 0; cnt_rd = 0; cnt_rsp = 0;
        last_rsp = -1; prev_rsp = -1; vrd_fall = -1; tri_rise = -1;
    endtask

    // Present one request; returns just after the accepting edge with req_valid low.
    task automatic send(input logic w, input logic [14:0] a, input logic [15:0] d,
                        input logic [1:0] be, output int acc);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            tests++; fails++;
            $display("FAIL accept_timeout: no req_ready within 60 cycles (cycle %0d)", cyc);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL ready_timeout: controller stayed busy (cycle %0d)", cyc);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [14:0] pool [16];

    initial begin
        int a1, a2, a3;
        for (int i = 0; i < 32768; i++) begin
            chip_a[i] = 8'h00; chip_b[i] = 8'h00; ref_a[i] = 8'h00; ref_b[i] = 8'h00;
        end
        chip_a[15'h0042] = 8'h5A; chip_b[15'h0042] = 8'hC3;
        ref_a[15'h0042]  = 8'h5A; ref_b[15'h0042]  = 8'hC3;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_vrd_n", vrd_n, 1'b1);
        chk("reset_tristate", vd_tristate, 1'b1);
        chk("reset_ready", req_ready, 1'b0);
        reset = 1'b1;

        // 1: first write after reset pays the turnaround
        clear_counts();
        send(1'b1, 15'h4123, 16'hB2A1, 2'b11, a1);
        chk("t1_va14", va14, 1'b1);
        chk("t1_vaa", vaa, 14'h0123);
        chk("t1_vab", vab, 14'h0123);
        chk("t1_vda_o", vda_o, 8'hA1);
        chk("t1_vdb_o", vdb_o, 8'hB2);
        wait_ready();
        chk("t1_awr_cycles", cnt_awr, 2);
        chk("t1_bwr_cycles", cnt_bwr, 2);
        chk("t1_rsp_count", cnt_rsp, 1);
        chk("t1_latency", last_rsp - a1, 6);

        // 2: read right after a write turns the bus around first
        clear_counts();
        send(1'b0, 15'h0042, 16'h0000, 2'b00, a2);
        wait_ready();
        chk("t2_rdata", rsp_rdata, 16'hC35A);
        chk("t2_latency", last_rsp - a2, 6);
        chk("t2_turn_lead", (vrd_fall - tri_rise) >= 2, 1'b1);
        chk("t2_rd_cycles", cnt_rd, 2);

        // 3: high-byte-only write
        clear_counts();
        send(1'b1, 15'h1234, 16'h7E00, 2'b10, a1);
        wait_ready();
        chk("t3_awr_cycles", cnt_awr, 0);
        chk("t3_bwr_cycles", cnt_bwr, 2);
        chk("t3_rsp_count", cnt_rsp, 1);

        // 4: back-to-back reads with req_valid held high
        clear_counts();
        send(1'b0, 15'h0042, 16'h0000, 2'b00, a1);
        send(1'b0, 15'h4123, 16'h0000, 2'b00, a2);
        send(1'b0, 15'h0042, 16'h0000, 2'b00, a3);
        wait_ready();
        chk("t4_ready_gap", a3 - a2, 5);
        chk("t4_rsp_gap", last_rsp - prev_rsp, 5);
        chk("t4_no_turn_latency", last_rsp - a3, 4);
        chk("t4_rsp_count", cnt_rsp, 3);
        chk("t4_rdata", rsp_rdata, 16'hC35A);

        // 5: reset in the second strobe cycle of a write
        clear_counts();
        send(1'b1, 15'h2AAA, 16'h1234, 2'b11, a1);
        while (cyc < a1 + T + S + 2) begin
            @(posedge clock); #1;
        end
        chk("t5_in_strobe", vawr_n, 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_vawr_n", vawr_n, 1'b1);
        chk("t5_vbwr_n", vbwr_n, 1'b1);
        chk("t5_tristate", vd_tristate, 1'b1);
        chk("t5_dir", lvl_vd_dir, 1'b0);
        chk("t5_ready_in_reset", req_ready, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t5_ready_after", req_ready, 1'b1);
        chk("t5_busy_after", busy, 1'b0);
        chk("t5_no_rsp", cnt_rsp, 0);
        @(posedge clock); #1;

        // 6: randomized mix against the reference memory
        for (int i = 0; i < 16; i++) pool[i] = 15'($urandom);
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
            send(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)],
                 16'($urandom), 2'($urandom_range(0, 3)), a1);
        end
        wait_ready();
        repeat (2) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
